reg_native_timeout_bridge: RTL

- Registered forwarding stage on the reg_native_if path, between regmst_reg_top (upstream) and one regslv_* block (downstream).
- Passes each single outstanding request downstream and returns the downstream acknowledge upstream.
- If the regslv never acknowledges, it completes the transaction itself with ERR_DATA, so the regmst/APB side cannot hang.
- Provides sticky error flags and a registered soft-reset pass-through.

---
 rtl/reg_native_timeout_bridge.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/reg_native_timeout_bridge.sv
// reg_native_timeout_bridge
// Registered forwarding stage between regmst_reg_top (upstream) and one
// regslv_* block (downstream) on the reg_native_if path. One transaction is
// outstanding at a time. If the regslv never acknowledges, the bridge
// completes the transaction itself with ERR_DATA so the upstream cannot hang.
//
// Ports:
//   fsm_clk, fsm_rstn        clock, synchronous active-low reset
//   up_req_vld/wr_en/rd_en   request from regmst, with up_addr/up_wr_data
//   up_ack_vld, up_rd_data   completion pulse and read data to regmst
//   dn_req_vld/wr_en/rd_en   forwarded request, with dn_addr/dn_wr_data
//   dn_ack_vld, dn_rd_data   completion pulse and read data from regslv
//   soft_rst, soft_rst_o     synchronous abort, and its one-cycle delayed copy
//   clear                    clears the sticky error flags
//   timeout_err, stray_ack_err, proto_err   sticky error flags
module reg_native_timeout_bridge #(
  parameter int          ADDR_WIDTH     = 64,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 8,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                  fsm_clk,
  input  logic                  fsm_rstn,
  input  logic                  up_req_vld,
  input  logic                  up_wr_en,
  input  logic                  up_rd_en,
  input  logic [ADDR_WIDTH-1:0] up_addr,
  input  logic [DATA_WIDTH-1:0] up_wr_data,
  output logic                  up_ack_vld,
  output logic [DATA_WIDTH-1:0] up_rd_data,
  output logic                  dn_req_vld,
  output logic                  dn_wr_en,
  output logic                  dn_rd_en,
  output logic [ADDR_WIDTH-1:0] dn_addr,
  output logic [DATA_WIDTH-1:0] dn_wr_data,
  input  logic                  dn_ack_vld,
  input  logic [DATA_WIDTH-1:0] dn_rd_data,
  input  logic                  soft_rst,
  output logic                  soft_rst_o,
  input  logic                  clear,
  output logic                  timeout_err,
  output logic                  stray_ack_err,
  output logic                  proto_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_VAL  = DATA_WIDTH'(ERR_DATA);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             capture_s;   // latch upstream request fields
  logic             take_ack_s;  // latch dn_rd_data as the response
  logic             tmo_s;       // timeout fires this cycle
  logic             proto_s;     // request arrived while busy
  logic             stray_s;     // ack arrived with nothing waiting for it

  // Next-state, counter and event decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    capture_s  = 1'b0;
    take_ack_s = 1'b0;
    tmo_s      = 1'b0;
    proto_s    = 1'b0;
    stray_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stray_s = dn_ack_vld;
        if (up_req_vld) begin
          capture_s = 1'b1;
          state_s   = ST_ISSUE;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        proto_s = up_req_vld;
        // A regslv may answer in the same cycle it sees the request.
        if (dn_ack_vld) begin
          take_ack_s = 1'b1;
          state_s    = ST_RESP;
        end else begin
          cnt_s      = {CNT_W{1'b0}};
          state_s    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        proto_s = up_req_vld;
        // Ack is checked first so it wins over a coincident timeout.
        if (dn_ack_vld) begin
          take_ack_s = 1'b1;
          state_s    = ST_RESP;
        end else if (cnt_r == CNT_LAST) begin
          tmo_s      = 1'b1;
          state_s    = ST_RESP;
        end else begin
          cnt_s      = cnt_r + CNT_W'(1);
        end
      end
      ST_RESP: begin
        proto_s = up_req_vld;
        stray_s = dn_ack_vld;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
    // Soft reset aborts whatever is in flight; the aborted request gets no ack.
    if (soft_rst) begin
      state_s    = ST_IDLE;
      cnt_s      = {CNT_W{1'b0}};
      capture_s  = 1'b0;
      take_ack_s = 1'b0;
      tmo_s      = 1'b0;
    end else begin
      state_s    = state_s;
    end
  end

  // State register, counter, and pulse outputs derived from the next state.
  always_ff @(posedge fsm_clk) begin
    if (!fsm_rstn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      dn_req_vld <= 1'b0;
      up_ack_vld <= 1'b0;
      soft_rst_o <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      dn_req_vld <= (state_s == ST_ISSUE);
      up_ack_vld <= (state_s == ST_RESP);
      soft_rst_o <= soft_rst;
    end
  end

  // Downstream request fields, held from one capture to the next.
  always_ff @(posedge fsm_clk) begin
    if (!fsm_rstn) begin
      dn_wr_en   <= 1'b0;
      dn_rd_en   <= 1'b0;
      dn_addr    <= {ADDR_WIDTH{1'b0}};
      dn_wr_data <= {DATA_WIDTH{1'b0}};
    end else if (capture_s) begin
      dn_wr_en   <= up_wr_en;
      dn_rd_en   <= up_rd_en;
      dn_addr    <= up_addr;
      dn_wr_data <= up_wr_data;
    end
  end

  // Response data: regslv data on ack, ERR_VAL on timeout, else held.
  always_ff @(posedge fsm_clk) begin
    if (!fsm_rstn) begin
      up_rd_data <= {DATA_WIDTH{1'b0}};
    end else if (take_ack_s) begin
      up_rd_data <= dn_rd_data;
    end else if (tmo_s) begin
      up_rd_data <= ERR_VAL;
    end
  end

  // Sticky error flags: set beats clear; frozen while soft reset is asserted.
  always_ff @(posedge fsm_clk) begin
    if (!fsm_rstn) begin
      timeout_err   <= 1'b0;
      stray_ack_err <= 1'b0;
      proto_err     <= 1'b0;
    end else if (!soft_rst) begin
      timeout_err   <= tmo_s   | (timeout_err   & ~clear);
      stray_ack_err <= stray_s | (stray_ack_err & ~clear);
      proto_err     <= proto_s | (proto_err     & ~clear);
    end
  end

endmodule
